// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: W pipeline register, 15-entry register file,
// and CPU status / halt / retired-instruction tracking.
module writeback_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG = 15,
  parameter int unsigned CNT_W = 32,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              W_stall_i,
  input  logic              W_bubble_i,
  input  logic [2:0]        M_stat_i,
  input  logic [3:0]        M_icode_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [DATA_W-1:0] M_valM_i,
  input  logic [3:0]        M_dstE_i,
  input  logic [3:0]        M_dstM_i,
  output logic [2:0]        W_stat_o,
  output logic [3:0]        W_icode_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [3:0]        W_dstE_o,
  output logic [3:0]        W_dstM_o,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  output logic [DATA_W-1:0] d_rvalA_o,
  output logic [DATA_W-1:0] d_rvalB_o,
  output logic [2:0]        stat_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] I_NOP = 4'h1;

  logic [2:0]        w_stat_q, w_stat_d;
  logic [3:0]        w_icode_q, w_icode_d;
  logic [DATA_W-1:0] w_valE_q, w_valE_d;
  logic [DATA_W-1:0] w_valM_q, w_valM_d;
  logic [3:0]        w_dstE_q, w_dstE_d;
  logic [3:0]        w_dstM_q, w_dstM_d;
  logic              w_valid_q, w_valid_d;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              halted_q, halted_d;
  logic [2:0]        hstat_q, hstat_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic commit;
  logic halt_ev;

  always_comb begin
    commit  = !W_stall_i && w_valid_q && (w_stat_q == S_AOK) && !halted_q;
    halt_ev = w_valid_q && (w_stat_q != S_AOK) && !halted_q;
  end

  // Stall wins over bubble so a held instruction is never lost.
  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_valE_d  = w_valE_q;
    w_valM_d  = w_valM_q;
    w_dstE_d  = w_dstE_q;
    w_dstM_d  = w_dstM_q;
    w_valid_d = w_valid_q;
    if (W_stall_i) begin
      w_valid_d = w_valid_q;
    end else if (W_bubble_i) begin
      w_stat_d  = S_AOK;
      w_icode_d = I_NOP;
      w_valE_d  = '0;
      w_valM_d  = '0;
      w_dstE_d  = RNONE;
      w_dstM_d  = RNONE;
      w_valid_d = 1'b0;
    end else begin
      w_stat_d  = M_stat_i;
      w_icode_d = M_icode_i;
      w_valE_d  = M_valE_i;
      w_valM_d  = M_valM_i;
      w_dstE_d  = M_dstE_i;
      w_dstM_d  = M_dstM_i;
      w_valid_d = 1'b1;
    end
  end

  // valM port applied last so popq %rsp leaves the loaded value.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && w_dstE_q == 4'(i)) regs_d[i] = w_valE_q;
      if (commit && w_dstM_q == 4'(i)) regs_d[i] = w_valM_q;
    end
  end

  always_comb begin
    halted_d  = halted_q | halt_ev;
    hstat_d   = halt_ev ? w_stat_q : hstat_q;
    retired_d = commit ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_stat_q  <= S_AOK;
      w_icode_q <= I_NOP;
      w_valE_q  <= '0;
      w_valM_q  <= '0;
      w_dstE_q  <= RNONE;
      w_dstM_q  <= RNONE;
      w_valid_q <= 1'b0;
      halted_q  <= 1'b0;
      hstat_q   <= S_AOK;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (i == 4) ? RSP_RESET : '0;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_valE_q  <= w_valE_d;
      w_valM_q  <= w_valM_d;
      w_dstE_q  <= w_dstE_d;
      w_dstM_q  <= w_dstM_d;
      w_valid_q <= w_valid_d;
      halted_q  <= halted_d;
      hstat_q   <= hstat_d;
      retired_q <= retired_d;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (d_srcA_i == 4'(i)) rd_a = regs_q[i];
      if (d_srcB_i == 4'(i)) rd_b = regs_q[i];
    end
  end

  assign W_stat_o  = w_stat_q;
  assign W_icode_o = w_icode_q;
  assign W_valE_o  = w_valE_q;
  assign W_valM_o  = w_valM_q;
  assign W_dstE_o  = w_dstE_q;
  assign W_dstM_o  = w_dstM_q;
  assign d_rvalA_o = rd_a;
  assign d_rvalB_o = rd_b;
  assign stat_o    = halted_q ? hstat_q : (w_valid_q ? w_stat_q : S_AOK);
  assign halted_o  = halted_q;
  assign retired_o = retired_q;

endmodule
